// File: rtl/trng_pkg.sv
// Shared types and constants for the trng entropy arbitration blocks.
package trng_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    DELIVER = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_NUM_SOURCES = 4;
  localparam int unsigned DEFAULT_DATA_WIDTH  = 32;

  // Source id width; never narrower than one bit.
  function automatic int unsigned src_id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit at or after rr_ptr, with wrap.
module rr_picker
  import trng_pkg::*;
#(
  parameter int unsigned NUM_SOURCES = DEFAULT_NUM_SOURCES,
  parameter int unsigned SRC_W       = src_id_width(NUM_SOURCES)
) (
  input  logic [NUM_SOURCES-1:0] req,
  input  logic [SRC_W-1:0]       rr_ptr,
  output logic [SRC_W-1:0]       grant,
  output logic                   grant_valid
);

  logic [SRC_W-1:0] idx;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
      idx = SRC_W'((32'(rr_ptr) + k) % NUM_SOURCES);
      if (!grant_valid && req[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/entropy_source_arbiter.sv
// Round-robin arbiter forwarding one entropy word at a time from NUM_SOURCES providers to one consumer.
module entropy_source_arbiter
  import trng_pkg::*;
#(
  parameter  int unsigned NUM_SOURCES = DEFAULT_NUM_SOURCES,
  parameter  int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  localparam int unsigned SRC_W       = src_id_width(NUM_SOURCES)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              enable,
  input  logic [NUM_SOURCES-1:0]            src_enable,
  input  logic [NUM_SOURCES-1:0]            src_syn,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SOURCES-1:0]            src_ack,
  output logic                              entropy_syn,
  output logic [DATA_WIDTH-1:0]             entropy_data,
  output logic [SRC_W-1:0]                  entropy_src,
  input  logic                              entropy_ack,
  output logic                              busy,
  input  logic                              clear_stats,
  input  logic [SRC_W-1:0]                  stat_sel,
  output logic [31:0]                       stat_count
);

  localparam int unsigned SEL_SPAN = 2 ** SRC_W;

  state_t state, state_next;
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] pick;
  logic             pick_valid;
  logic [NUM_SOURCES-1:0] req;
  logic [NUM_SOURCES-1:0][DATA_WIDTH-1:0] src_words;
  logic [NUM_SOURCES-1:0][31:0] count;
  logic [SEL_SPAN-1:0][31:0]    count_view;
  logic deliver_done;

  assign req          = enable ? (src_syn & src_enable) : '0;
  assign src_words    = src_data;
  assign deliver_done = (state == DELIVER) && entropy_ack;

  rr_picker #(
    .NUM_SOURCES (NUM_SOURCES),
    .SRC_W       (SRC_W)
  ) u_picker (
    .req         (req),
    .rr_ptr      (rr_ptr),
    .grant       (pick),
    .grant_valid (pick_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (pick_valid) state_next = ACK;
      ACK:     state_next = DELIVER;
      DELIVER: if (entropy_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // entropy_src doubles as the grant register for the ack pulse and counter index.
  always_comb begin
    src_ack = '0;
    if (state == ACK) src_ack[entropy_src] = 1'b1;
    entropy_syn = (state == DELIVER);
    busy        = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr       <= '0;
      entropy_data <= '0;
      entropy_src  <= '0;
    end else if (state == IDLE && pick_valid) begin
      entropy_data <= src_words[pick];
      entropy_src  <= pick;
      rr_ptr       <= (pick == SRC_W'(NUM_SOURCES - 1)) ? '0 : pick + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear_stats) begin
      count <= '0;
    end else if (deliver_done) begin
      count[entropy_src] <= count[entropy_src] + 32'd1;
    end
  end

  // Pad the counter view to the full select range so out-of-range ids read zero.
  for (genvar i = 0; i < SEL_SPAN; i++) begin : g_view
    if (i < NUM_SOURCES) begin : g_real
      assign count_view[i] = count[i];
    end else begin : g_pad
      assign count_view[i] = '0;
    end
  end

  assign stat_count = count_view[stat_sel];

endmodule
